// File: rtl/dom_and_param.sv
// Order-D masked AND gadget (DOM) with valid/ready handshake and optional output stage.
// Every output share is compressed only from registered partial products.

module dom_and_lane #(
    parameter int N = 3,
    parameter int W = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ld,
    input  logic [W-1:0]        x,
    input  logic [N-1:0][W-1:0] y,
    input  logic [N-1:0][W-1:0] zr,
    output logic [W-1:0]        q
);
    // Slot j holds x & y[j] ^ zr[j]; the own-domain slot gets zr = 0 and so holds s.
    logic [N-1:0][W-1:0] c_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            c_q <= '0;
        end else if (ld) begin
            for (int j = 0; j < N; j++) begin
                c_q[j] <= (x & y[j]) ^ zr[j];
            end
        end
    end

    always_comb begin
        q = '0;
        for (int j = 0; j < N; j++) begin
            q = q ^ c_q[j];
        end
    end
endmodule

module dom_and_param #(
    parameter int D       = 2,
    parameter int W       = 8,
    parameter int OUT_REG = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       valid_i,
    output logic                       ready_o,
    input  logic [(D+1)*W-1:0]         X_i,
    input  logic [(D+1)*W-1:0]         Y_i,
    input  logic [(D*(D+1)/2)*W-1:0]   Z_i,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [(D+1)*W-1:0]         Q_o
);
    localparam int N      = D + 1;
    localparam int NR     = D * (D + 1) / 2;
    localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

    typedef struct packed {
        logic [N-1:0][W-1:0]  x;
        logic [N-1:0][W-1:0]  y;
        logic [NR-1:0][W-1:0] z;
    } dom_req_t;

    // Word shared by the unordered pair (a,b); symmetric in its arguments.
    function automatic int ridx(input int a, input int b);
        int lo, hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        return lo * N - lo * (lo + 1) / 2 + (hi - lo - 1);
    endfunction

    dom_req_t                      req;
    logic [N-1:0][N-1:0][W-1:0]    zr;
    logic [N-1:0][W-1:0]           q1;
    logic [STAGES:1]               vld_pipe;
    logic                          ld1;

    assign req = {X_i, Y_i, Z_i};
    assign ld1 = valid_i & ready_o;

    for (genvar i = 0; i < N; i++) begin : g_lane
        for (genvar j = 0; j < N; j++) begin : g_z
            if (i == j) begin : g_own
                assign zr[i][j] = '0;
            end else begin : g_cross
                localparam int R = ridx(i, j);
                assign zr[i][j] = req.z[R];
            end
        end

        dom_and_lane #(.N(N), .W(W)) u_lane (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .ld    (ld1),
            .x     (req.x[i]),
            .y     (req.y),
            .zr    (zr[i]),
            .q     (q1[i])
        );
    end

    if (OUT_REG == 0) begin : g_out_comb
        assign ready_o = !vld_pipe[1] | ready_i;
        assign valid_o = vld_pipe[1];
        assign Q_o     = q1;

        always_ff @(posedge clk_i) begin
            if (!rst_ni)        vld_pipe[1] <= 1'b0;
            else if (ld1)       vld_pipe[1] <= 1'b1;
            else if (ready_i)   vld_pipe[1] <= 1'b0;
        end
    end else begin : g_out_reg
        logic [N-1:0][W-1:0] q2;
        logic                adv2;

        // Stage 1 may advance whenever stage 2 is empty or draining this cycle.
        assign adv2    = vld_pipe[1] & (!vld_pipe[2] | ready_i);
        assign ready_o = !vld_pipe[1] | adv2;
        assign valid_o = vld_pipe[2];
        assign Q_o     = q2;

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                vld_pipe <= '0;
                q2       <= '0;
            end else begin
                if (ld1)        vld_pipe[1] <= 1'b1;
                else if (adv2)  vld_pipe[1] <= 1'b0;

                if (adv2) begin
                    vld_pipe[2] <= 1'b1;
                    q2          <= q1;
                end else if (ready_i) begin
                    vld_pipe[2] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_dom_and_param.sv
// Bench for dom_and_param: D=2/W=8 single-stage plus D=1 and D=3 (W=4) two-stage instances.
module tb_dom_and_param;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // D=2, W=8, OUT_REG=0
    logic        v0, r0, vo0, ri0;
    logic [23:0] x0, y0, z0, q0;
    // D=1, W=4, OUT_REG=1
    logic        v1, r1, vo1, ri1;
    logic [7:0]  x1, y1, q1;
    logic [3:0]  z1;
    // D=3, W=4, OUT_REG=1
    logic        v3, r3, vo3, ri3;
    logic [15:0] x3, y3, q3;
    logic [23:0] z3;

    logic [63:0] eq0[$], eu0[$], eq1[$], eu1[$], eq3[$], eu3[$];

    dom_and_param #(.D(2), .W(8), .OUT_REG(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v0), .ready_o(r0), .X_i(x0), .Y_i(y0),
        .Z_i(z0), .valid_o(vo0), .ready_i(ri0), .Q_o(q0));
    dom_and_param #(.D(1), .W(4), .OUT_REG(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v1), .ready_o(r1), .X_i(x1), .Y_i(y1),
        .Z_i(z1), .valid_o(vo1), .ready_i(ri1), .Q_o(q1));
    dom_and_param #(.D(3), .W(4), .OUT_REG(1)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v3), .ready_o(r3), .X_i(x3), .Y_i(y3),
        .Z_i(z3), .valid_o(vo3), .ready_i(ri3), .Q_o(q3));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] fold(input int n, input int w, input logic [63:0] v);
        logic [63:0] m = (64'd1 << w) - 1;
        logic [63:0] a = '0;
        for (int i = 0; i < n; i++) a ^= (v >> (i * w)) & m;
        return a;
    endfunction

    // Reference share computation straight from the DOM-AND equations.
    function automatic logic [63:0] dom_model(input int n, input int w,
                                              input logic [63:0] x, y, z);
        logic [63:0] m = (64'd1 << w) - 1;
        logic [63:0] q = '0;
        logic [63:0] acc, xi;
        int lo, hi, r;
        for (int i = 0; i < n; i++) begin
            xi  = (x >> (i * w)) & m;
            acc = xi & (y >> (i * w)) & m;
            for (int j = 0; j < n; j++) begin
                if (j != i) begin
                    lo = (i < j) ? i : j;
                    hi = (i < j) ? j : i;
                    r  = lo * n - lo * (lo + 1) / 2 + (hi - lo - 1);
                    acc ^= ((xi & (y >> (j * w))) ^ (z >> (r * w))) & m;
                end
            end
            q |= acc << (i * w);
        end
        return q;
    endfunction

    function automatic logic [63:0] split(input int n, input int w, input logic [63:0] v);
        logic [63:0] m = (64'd1 << w) - 1;
        logic [63:0] r = '0;
        logic [63:0] a = '0;
        logic [63:0] s;
        for (int i = 0; i < n - 1; i++) begin
            s = {$urandom, $urandom} & m;
            r |= s << (i * w);
            a ^= s;
        end
        r |= ((v ^ a) & m) << ((n - 1) * w);
        return r;
    endfunction

    always @(negedge clk) if (rst_n && vo0 && ri0) begin
        if (eq0.size() == 0) chk("m0_spurious", {63'd0, vo0}, 64'd0);
        else begin
            chk("m0_q", q0, eq0.pop_front());
            chk("m0_xy", fold(3, 8, q0), eu0.pop_front());
        end
    end
    always @(negedge clk) if (rst_n && vo1 && ri1) begin
        if (eq1.size() == 0) chk("m1_spurious", {63'd0, vo1}, 64'd0);
        else begin
            chk("m1_q", q1, eq1.pop_front());
            chk("m1_xy", fold(2, 4, q1), eu1.pop_front());
        end
    end
    always @(negedge clk) if (rst_n && vo3 && ri3) begin
        if (eq3.size() == 0) chk("m3_spurious", {63'd0, vo3}, 64'd0);
        else begin
            chk("m3_q", q3, eq3.pop_front());
            chk("m3_xy", fold(4, 4, q3), eu3.pop_front());
        end
    end

    task automatic op0(input logic [23:0] x, input logic [23:0] y, input logic [23:0] z);
        bit ok = 0;
        x0 = x; y0 = y; z0 = z; v0 = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (r0) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (ok) begin
            eq0.push_back(dom_model(3, 8, x, y, z));
            eu0.push_back(fold(3, 8, x) & fold(3, 8, y));
            @(posedge clk); #1;
        end else chk("tmo0", 64'd0, 64'd1);
        v0 = 1'b0; x0 = $urandom; y0 = $urandom; z0 = $urandom;
    endtask

    task automatic op1(input logic [7:0] x, input logic [7:0] y, input logic [3:0] z, input bit rnd);
        bit ok = 0;
        x1 = x; y1 = y; z1 = z; v1 = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (r1) begin ok = 1; break; end
            @(posedge clk); #1;
            if (rnd) ri1 = 1'($urandom_range(0, 1));
        end
        if (ok) begin
            eq1.push_back(dom_model(2, 4, x, y, z));
            eu1.push_back(fold(2, 4, x) & fold(2, 4, y));
            @(posedge clk); #1;
            if (rnd) ri1 = ($urandom_range(0, 2) != 0);
        end else chk("tmo1", 64'd0, 64'd1);
        v1 = 1'b0; x1 = 8'($urandom); y1 = 8'($urandom); z1 = 4'($urandom);
    endtask

    task automatic op3(input logic [15:0] x, input logic [15:0] y, input logic [23:0] z, input bit rnd);
        bit ok = 0;
        x3 = x; y3 = y; z3 = z; v3 = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (r3) begin ok = 1; break; end
            @(posedge clk); #1;
            if (rnd) ri3 = 1'($urandom_range(0, 1));
        end
        if (ok) begin
            eq3.push_back(dom_model(4, 4, x, y, z));
            eu3.push_back(fold(4, 4, x) & fold(4, 4, y));
            @(posedge clk); #1;
            if (rnd) ri3 = ($urandom_range(0, 2) != 0);
        end else chk("tmo3", 64'd0, 64'd1);
        v3 = 1'b0; x3 = 16'($urandom); y3 = 16'($urandom); z3 = 24'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] xa, ya, xb, yb, za;
        logic [63:0] qa;
        int t;

        rst_n = 1'b0;
        v0 = 0; v1 = 0; v3 = 0; ri0 = 1; ri1 = 1; ri3 = 1;
        x0 = '0; y0 = '0; z0 = '0; x1 = '0; y1 = '0; z1 = '0; x3 = '0; y3 = '0; z3 = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_vo0", {63'd0, vo0}, 64'd0);
        chk("rst_q0", q0, 64'd0);
        chk("rst_rdy0", {63'd0, r0}, 64'd1);
        chk("rst_vo1", {63'd0, vo1}, 64'd0);
        chk("rst_q3", q3, 64'd0);
        chk("rst_rdy3", {63'd0, r3}, 64'd1);
        @(posedge clk); #1;

        // Directed vector, latency 1.
        op0(24'h962211, 24'hC3F00F, 24'($urandom));
        @(negedge clk);
        chk("lat0", {63'd0, vo0}, 64'd1);
        chk("unmask0", fold(3, 8, q0), 64'h24);
        @(posedge clk); #1;

        for (int k = 0; k < 1000; k++) op0(24'h962211, 24'hC3F00F, 24'($urandom));

        // 16 back-to-back ops must each take exactly one cycle.
        t = cyc;
        for (int k = 0; k < 16; k++) op0(24'($urandom), 24'($urandom), 24'($urandom));
        chk("tput0", 64'(cyc - t), 64'd16);
        repeat (2) @(posedge clk); #1;

        // Backpressure: op A stalls in stage 1 while op B waits.
        ri0 = 1'b0;
        xa = 24'($urandom); ya = 24'($urandom); za = 24'($urandom);
        qa = dom_model(3, 8, xa, ya, za);
        op0(xa, ya, za);
        xb = 24'($urandom); yb = 24'($urandom);
        x0 = xb; y0 = yb; z0 = 24'h5A5A5A; v0 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_vld", {63'd0, vo0}, 64'd1);
            chk("bp_q", q0, qa);
            chk("bp_rdy", {63'd0, r0}, 64'd0);
            @(posedge clk); #1;
        end
        ri0 = 1'b1;
        @(negedge clk);
        chk("bp_rdy_rel", {63'd0, r0}, 64'd1);
        eq0.push_back(dom_model(3, 8, xb, yb, 24'h5A5A5A));
        eu0.push_back(fold(3, 8, xb) & fold(3, 8, yb));
        @(posedge clk); #1;
        v0 = 1'b0;
        @(negedge clk);
        chk("bp_next", {63'd0, vo0}, 64'd1);
        @(posedge clk); #1;

        // Reset while an op sits in stage 1: it must never surface.
        ri0 = 1'b0;
        x0 = 24'($urandom); y0 = 24'($urandom); z0 = 24'($urandom); v0 = 1'b1;
        @(negedge clk);
        chk("rm_acc", {63'd0, r0}, 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0; ri0 = 1'b1; x0 = 24'hFFFFFF; y0 = 24'hFFFFFF;
        @(posedge clk); #1;
        rst_n = 1'b1; v0 = 1'b0;
        @(negedge clk);
        chk("rm_vo", {63'd0, vo0}, 64'd0);
        chk("rm_q", q0, 64'd0);
        chk("rm_rdy", {63'd0, r0}, 64'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rm_quiet", {63'd0, vo0}, 64'd0);
        @(posedge clk); #1;

        // D=1: latency 2, then random splits under random backpressure.
        op1(8'(split(2, 4, 64'hB)), 8'(split(2, 4, 64'h6)), 4'($urandom), 1'b0);
        @(negedge clk);
        chk("lat1a", {63'd0, vo1}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat1b", {63'd0, vo1}, 64'd1);
        @(posedge clk); #1;
        for (int k = 0; k < 300; k++)
            op1(8'(split(2, 4, 64'($urandom_range(0, 15)))), 8'(split(2, 4, 64'($urandom_range(0, 15)))),
                4'($urandom), 1'b1);
        ri1 = 1'b1;
        for (int k = 0; k < 20 && eq1.size() != 0; k++) @(posedge clk);
        #1 chk("drain1", 64'(eq1.size()), 64'd0);

        // D=3: same treatment.
        op3(16'(split(4, 4, 64'hD)), 16'(split(4, 4, 64'h7)), 24'($urandom), 1'b0);
        @(negedge clk);
        chk("lat3a", {63'd0, vo3}, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat3b", {63'd0, vo3}, 64'd1);
        @(posedge clk); #1;
        for (int k = 0; k < 300; k++)
            op3(16'(split(4, 4, 64'($urandom_range(0, 15)))), 16'(split(4, 4, 64'($urandom_range(0, 15)))),
                24'($urandom), 1'b1);
        ri3 = 1'b1;
        for (int k = 0; k < 20 && eq3.size() != 0; k++) @(posedge clk);
        #1 chk("drain3", 64'(eq3.size()), 64'd0);

        repeat (3) @(posedge clk);
        #1 chk("drain0", 64'(eq0.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
